// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Brief    : Shared constants for the pipeline front end.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_REGWRITE = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

endpackage
`default_nettype wire

// File: rtl/stall_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : stall_watchdog
//  Brief    : Counts consecutive frozen-PC cycles; sticky flag at MAX_STALL.
//  Revision : 1.0  initial release
// ============================================================================
module stall_watchdog #(
    parameter int MAX_STALL = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pc_write,
    input  logic i_branch_taken,
    output logic o_stall_timeout
);

    localparam int                   c_RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [c_RUN_W-1:0]   c_RUN_MAX = c_RUN_W'(MAX_STALL);

    logic [c_RUN_W-1:0] r_stall_run;
    logic [c_RUN_W-1:0] w_run_next;
    logic               r_stall_timeout;

    // A taken branch moves the PC, so it breaks the frozen run.
    always_comb begin
        w_run_next = '0;
        if (!i_pc_write && !i_branch_taken) begin
            w_run_next = (r_stall_run == c_RUN_MAX) ? r_stall_run
                                                    : r_stall_run + c_RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_run     <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_stall_run     <= w_run_next;
            r_stall_timeout <= r_stall_timeout | (w_run_next == c_RUN_MAX);
        end
    end

    assign o_stall_timeout = r_stall_timeout;

endmodule
`default_nettype wire

// File: rtl/pipe_front_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_front_ctrl
//  Brief    : PC, IF/ID and ID/EX front-end registers with stall/flush control.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_front_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = 8,
    parameter int          MAX_STALL = 8,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCwrite,
    input  logic              IF_ID_write,
    input  logic              stall_select,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_rdata,
    input  logic [CTRL_W-1:0] id_ctrl_in,
    output logic [31:0]       imem_addr,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic [4:0]        current_rs,
    output logic [4:0]        current_rt,
    output logic              current_memread,
    output logic              current_memwrite_sw,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic              ID_EX_memread,
    output logic              ID_EX_memwrite_sw,
    output logic [4:0]        ID_EX_Regrt,
    output logic [4:0]        ID_EX_Regrd,
    output logic [CNT_W-1:0]  bubble_count,
    output logic              stall_timeout
);

    logic [31:0]       r_pc;
    logic [31:0]       r_if_id_instr;
    logic [31:0]       r_if_id_pc4;
    logic [CTRL_W-1:0] r_id_ex_ctrl;
    logic [4:0]        r_id_ex_regrt;
    logic [4:0]        r_id_ex_regrd;
    logic [CNT_W-1:0]  r_bubble_count;
    logic [31:0]       w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_pc <= branch_target;
        end else if (PCwrite) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || branch_taken) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= '0;
        end else if (IF_ID_write) begin
            r_if_id_instr <= imem_rdata;
            r_if_id_pc4   <= w_pc_plus4;
        end
    end

    // Flush bubbles are not counted; only hazard-driven stall bubbles are.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_ex_ctrl   <= '0;
            r_id_ex_regrt  <= '0;
            r_id_ex_regrd  <= '0;
            r_bubble_count <= '0;
        end else if (branch_taken) begin
            r_id_ex_ctrl  <= '0;
            r_id_ex_regrt <= '0;
            r_id_ex_regrd <= '0;
        end else if (!stall_select) begin
            r_id_ex_ctrl  <= '0;
            r_id_ex_regrt <= '0;
            r_id_ex_regrd <= '0;
            if (!(&r_bubble_count)) begin
                r_bubble_count <= r_bubble_count + CNT_W'(1);
            end
        end else begin
            r_id_ex_ctrl  <= id_ctrl_in;
            r_id_ex_regrt <= r_if_id_instr[RT_MSB:RT_LSB];
            r_id_ex_regrd <= r_if_id_instr[RD_MSB:RD_LSB];
        end
    end

    stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_watchdog (
        .clk             (clk),
        .reset           (reset),
        .i_pc_write      (PCwrite),
        .i_branch_taken  (branch_taken),
        .o_stall_timeout (stall_timeout)
    );

    assign imem_addr           = r_pc;
    assign if_id_instr         = r_if_id_instr;
    assign if_id_pc4           = r_if_id_pc4;
    assign current_rs          = r_if_id_instr[RS_MSB:RS_LSB];
    assign current_rt          = r_if_id_instr[RT_MSB:RT_LSB];
    assign current_memread     = id_ctrl_in[CTRL_MEMREAD];
    assign current_memwrite_sw = id_ctrl_in[CTRL_MEMWRITE];
    assign ID_EX_ctrl          = r_id_ex_ctrl;
    assign ID_EX_memread       = r_id_ex_ctrl[CTRL_MEMREAD];
    assign ID_EX_memwrite_sw   = r_id_ex_ctrl[CTRL_MEMWRITE];
    assign ID_EX_Regrt         = r_id_ex_regrt;
    assign ID_EX_Regrd         = r_id_ex_regrd;
    assign bubble_count        = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_front_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_front_ctrl
//  Brief    : Directed + random bench against a behavioural front-end model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_front_ctrl;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_0040;
    localparam int          c_CTRL_W    = 8;
    localparam int          c_MAX_STALL = 8;
    localparam int          c_CNT_W     = 4;
    localparam int          c_CNT_MAX   = (1 << c_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                PCwrite = 1'b0;
    logic                IF_ID_write = 1'b0;
    logic                stall_select = 1'b1;
    logic                branch_taken = 1'b0;
    logic [31:0]         branch_target = '0;
    logic [31:0]         imem_rdata;
    logic [c_CTRL_W-1:0] id_ctrl_in = '0;
    logic [31:0]         imem_addr;
    logic [31:0]         if_id_instr;
    logic [31:0]         if_id_pc4;
    logic [4:0]          current_rs;
    logic [4:0]          current_rt;
    logic                current_memread;
    logic                current_memwrite_sw;
    logic [c_CTRL_W-1:0] ID_EX_ctrl;
    logic                ID_EX_memread;
    logic                ID_EX_memwrite_sw;
    logic [4:0]          ID_EX_Regrt;
    logic [4:0]          ID_EX_Regrd;
    logic [c_CNT_W-1:0]  bubble_count;
    logic                stall_timeout;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic [7:0]  m_ctrl;
    int          m_rt, m_rd, m_bub, m_run;
    logic        m_to;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h8C4A_3000;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    pipe_front_ctrl #(
        .RESET_PC  (c_RESET_PC),
        .CTRL_W    (c_CTRL_W),
        .MAX_STALL (c_MAX_STALL),
        .CNT_W     (c_CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .PCwrite             (PCwrite),
        .IF_ID_write         (IF_ID_write),
        .stall_select        (stall_select),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .imem_rdata          (imem_rdata),
        .id_ctrl_in          (id_ctrl_in),
        .imem_addr           (imem_addr),
        .if_id_instr         (if_id_instr),
        .if_id_pc4           (if_id_pc4),
        .current_rs          (current_rs),
        .current_rt          (current_rt),
        .current_memread     (current_memread),
        .current_memwrite_sw (current_memwrite_sw),
        .ID_EX_ctrl          (ID_EX_ctrl),
        .ID_EX_memread       (ID_EX_memread),
        .ID_EX_memwrite_sw   (ID_EX_memwrite_sw),
        .ID_EX_Regrt         (ID_EX_Regrt),
        .ID_EX_Regrd         (ID_EX_Regrd),
        .bubble_count        (bubble_count),
        .stall_timeout       (stall_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_addr",   imem_addr,   m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc4",   if_id_pc4,   m_pc4);
        chk("current_rs",  {27'd0, current_rs}, (m_instr >> 21) & 32'd31);
        chk("current_rt",  {27'd0, current_rt}, (m_instr >> 16) & 32'd31);
        chk("current_memread",     {31'd0, current_memread},     32'(id_ctrl_in % 2));
        chk("current_memwrite_sw", {31'd0, current_memwrite_sw}, 32'((id_ctrl_in / 2) % 2));
        chk("ID_EX_ctrl",  {24'd0, ID_EX_ctrl}, {24'd0, m_ctrl});
        chk("ID_EX_memread",     {31'd0, ID_EX_memread},     32'(m_ctrl % 2));
        chk("ID_EX_memwrite_sw", {31'd0, ID_EX_memwrite_sw}, 32'((m_ctrl / 2) % 2));
        chk("ID_EX_Regrt", {27'd0, ID_EX_Regrt}, 32'(m_rt));
        chk("ID_EX_Regrd", {27'd0, ID_EX_Regrd}, 32'(m_rd));
        chk("bubble_count",  {28'd0, bubble_count}, 32'(m_bub));
        chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
    endtask

    // One clock: drive inputs, advance the model by the stage rules, compare.
    task automatic step(input logic rst, input logic pcw, input logic ifw,
                        input logic ss, input logic br, input logic [31:0] tgt,
                        input logic [7:0] ctl);
        logic [31:0] n_pc, n_instr, n_pc4;
        logic [7:0]  n_ctrl;
        int          n_rt, n_rd, n_bub, n_run;
        logic        n_to;
        @(negedge clk);
        reset = rst; PCwrite = pcw; IF_ID_write = ifw; stall_select = ss;
        branch_taken = br; branch_target = tgt; id_ctrl_in = ctl;
        if (rst) begin
            n_pc = c_RESET_PC; n_instr = 0; n_pc4 = 0; n_ctrl = 0;
            n_rt = 0; n_rd = 0; n_bub = 0; n_run = 0; n_to = 1'b0;
        end else begin
            n_pc = br ? tgt : (pcw ? m_pc + 32'd4 : m_pc);
            n_instr = br ? 32'd0 : (ifw ? mem_word(m_pc) : m_instr);
            n_pc4   = br ? 32'd0 : (ifw ? m_pc + 32'd4 : m_pc4);
            n_bub = m_bub;
            if (br || !ss) begin
                n_ctrl = 0; n_rt = 0; n_rd = 0;
                if (!br && m_bub < c_CNT_MAX) n_bub = m_bub + 1;
            end else begin
                n_ctrl = ctl;
                n_rt = int'((m_instr >> 16) & 32'd31);
                n_rd = int'((m_instr >> 11) & 32'd31);
            end
            n_run = (!pcw && !br) ? ((m_run + 1 > c_MAX_STALL) ? c_MAX_STALL : m_run + 1) : 0;
            n_to  = m_to || (n_run == c_MAX_STALL);
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_ctrl = n_ctrl;
        m_rt = n_rt; m_rd = n_rd; m_bub = n_bub; m_run = n_run; m_to = n_to;
        compare_all();
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_ctrl = 0;
        m_rt = 0; m_rd = 0; m_bub = 0; m_run = 0; m_to = 1'b0;

        // Reset and straight-line fetch
        step(1, 1, 1, 1, 0, 0, 8'h00);
        chk("lit_reset_pc",  imem_addr, 32'h40);
        chk("lit_reset_bub", {28'd0, bubble_count}, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 8'h00);
        chk("lit_fetch_pc",  imem_addr, 32'h4C);
        chk("lit_fetch_pc4", if_id_pc4, 32'h4C);
        chk("lit_fetch_ins", if_id_instr, mem_word(32'h48));

        // Load-use stall for two cycles
        step(0, 0, 0, 0, 0, 0, 8'h07);
        step(0, 0, 0, 0, 0, 0, 8'h07);
        chk("lit_stall_pc",  imem_addr, 32'h4C);
        chk("lit_stall_bub", {28'd0, bubble_count}, 32'd2);
        chk("lit_stall_ctl", {24'd0, ID_EX_ctrl}, 32'd0);

        // Branch during stall
        step(0, 0, 0, 0, 1, 32'h100, 8'h07);
        chk("lit_br_pc",    imem_addr, 32'h100);
        chk("lit_br_instr", if_id_instr, 32'd0);
        chk("lit_br_bub",   {28'd0, bubble_count}, 32'd2);

        // Field routing for lw at 0x200
        step(0, 1, 1, 1, 1, 32'h200, 8'h00);
        step(0, 1, 1, 1, 0, 0, 8'h05);
        chk("lit_rs", {27'd0, current_rs}, 32'd2);
        chk("lit_rt", {27'd0, current_rt}, 32'd10);
        step(0, 0, 0, 1, 0, 0, 8'h05);
        chk("lit_idex_rt", {27'd0, ID_EX_Regrt}, 32'd10);
        chk("lit_idex_rd", {27'd0, ID_EX_Regrd}, 32'd6);
        chk("lit_idex_mr", {31'd0, ID_EX_memread}, 32'd1);
        chk("lit_idex_mw", {31'd0, ID_EX_memwrite_sw}, 32'd0);

        // Watchdog
        step(1, 1, 1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, 8'h00);
        chk("lit_wd_7", {31'd0, stall_timeout}, 32'd0);
        step(0, 0, 0, 1, 0, 0, 8'h00);
        chk("lit_wd_8", {31'd0, stall_timeout}, 32'd1);
        step(0, 1, 1, 1, 0, 0, 8'h00);
        step(0, 1, 1, 1, 0, 0, 8'h00);
        chk("lit_wd_sticky", {31'd0, stall_timeout}, 32'd1);
        step(1, 1, 1, 1, 0, 0, 8'h00);
        chk("lit_wd_reset", {31'd0, stall_timeout}, 32'd0);

        // Bubble saturation and PC wrap
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 0, 8'h00);
        chk("lit_sat", {28'd0, bubble_count}, 32'd15);
        step(0, 1, 1, 1, 1, 32'hFFFF_FFFC, 8'h00);
        step(0, 1, 1, 1, 0, 0, 8'h00);
        chk("lit_wrap_pc",  imem_addr, 32'h0);
        chk("lit_wrap_pc4", if_id_pc4, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom() & 32'hFFFF_FFFC,
                 8'($urandom()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
